// File: rtl/div_radix2.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} held in END until the pipeline releases it.
module div_radix2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  input  logic               hold,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic [1:0]         dbgState
);

  // Handshake: start is sampled only in FREE; ready is high exactly while in END,
  // and the result is consumed on the first END cycle with hold low.
  typedef enum logic [1:0] {FREE = 2'd0, ZERO = 2'd1, ON = 2'd2, END = 2'd3} state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] counter;
  logic [2*WIDTH:0] work;
  logic [WIDTH-1:0] divisor;
  logic             negQuot, negRem;

  logic [WIDTH-1:0] absDividend, absDivisor;
  logic [2*WIDTH:0] shifted, stepWork;
  logic [WIDTH:0]   diff;
  logic             noBorrow, lastStep;
  logic [WIDTH-1:0] quotRaw, remRaw, finalQuot, finalRem;

  assign absDividend = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign absDivisor  = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // Upper WIDTH+1 bits hold the partial remainder, lower WIDTH bits collect the quotient.
  always_comb begin
    shifted  = {work[2*WIDTH-1:0], 1'b0};
    noBorrow = shifted[2*WIDTH:WIDTH] >= {1'b0, divisor};
    diff     = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
    stepWork = shifted;
    if (noBorrow) stepWork = {diff, shifted[WIDTH-1:1], 1'b1};
  end

  assign quotRaw   = stepWork[WIDTH-1:0];
  assign remRaw    = stepWork[2*WIDTH-1:WIDTH];
  assign finalQuot = negQuot ? -quotRaw : quotRaw;
  assign finalRem  = negRem ? -remRaw : remRaw;
  assign lastStep  = (counter == CNT_W'(WIDTH - 1));

  always_comb begin
    nextState = state;
    case (state)
      FREE:    if (start) nextState = (opdata2 == '0) ? ZERO : ON;
      ZERO:    nextState = END;
      ON:      if (lastStep) nextState = END;
      END:     if (!hold) nextState = FREE;
      default: nextState = FREE;
    endcase
    if (annul) nextState = FREE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      work    <= '0;
      divisor <= '0;
      negQuot <= 1'b0;
      negRem  <= 1'b0;
      result  <= '0;
    end else if (!annul) begin
      case (state)
        FREE: begin
          if (start && opdata2 != '0) begin
            divisor <= absDivisor;
            work    <= {{(WIDTH+1){1'b0}}, absDividend};
            negQuot <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            negRem  <= signed_div & opdata1[WIDTH-1];
            counter <= '0;
          end
        end
        ZERO: result <= '0;
        ON: begin
          work    <= stepWork;
          counter <= counter + CNT_W'(1);
          if (lastStep) result <= {finalRem, finalQuot};
        end
        default: ;
      endcase
    end
  end

  assign ready    = (state == END);
  assign dbgState = state;

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: latency, signed/unsigned results, divide by zero,
// annul, hold, mid-operation reset and back-to-back divides.
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul, hold;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  logic        ready;
  logic [1:0]  dbgState;

  int checks = 0;
  int errors = 0;

  div_radix2 dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .annul(annul), .hold(hold),
    .result(result), .ready(ready), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps edges until ready, bounded; cycles counts edges taken.
  task automatic wait_ready(input int maxCycles, inout int cycles);
    while (!ready && cycles < maxCycles) begin
      step();
      cycles++;
    end
  endtask

  // Starts a divide; when keep is 0 start drops after the first edge and the
  // operand inputs are scrambled to show they are no longer sampled.
  task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input logic keep, output logic [63:0] res, output int cycles);
    start = 1'b1; signed_div = sd; opdata1 = a; opdata2 = b;
    step();
    cycles = 1;
    if (!keep) begin
      start = 1'b0; signed_div = ~sd;
      opdata1 = $urandom; opdata2 = $urandom_range(1, 1000);
    end
    wait_ready(100, cycles);
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; hold = 1'b0;
    opdata1 = '0; opdata2 = '0;
    step(); step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (dbgState !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbgState); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned();
    logic [63:0] res; int cyc;
    run_div(1'b0, 32'd100, 32'd7, 1'b1, res, cyc);
    start = 1'b0;
    checks++; if (cyc !== 33) begin errors++; $display("FAIL udiv_latency got %0d want 33", cyc); end
    checks++; if (res !== 64'h00000002_0000000E) begin errors++; $display("FAIL udiv_100_7 got %h want 000000020000000e", res); end
    step();
    checks++; if (ready !== 1'b0 || dbgState !== 2'd0) begin errors++; $display("FAIL udiv_free_after got ready=%b state=%0d want 0/0", ready, dbgState); end
  endtask

  task automatic test_signed();
    logic [63:0] res; int cyc;
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, 1'b0, res, cyc);
    checks++; if (res !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL sdiv_m7_2 got %h want fffffffffffffffd", res); end
    step();
    run_div(1'b1, 32'h7, 32'hFFFFFFFE, 1'b0, res, cyc);
    checks++; if (res !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL sdiv_7_m2 got %h want 00000001fffffffd", res); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL sdiv_latency got %0d want 33", cyc); end
    step();
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, res, cyc);
    checks++; if (res !== 64'h00000000_80000000) begin errors++; $display("FAIL sdiv_overflow got %h want 0000000080000000", res); end
    step();
  endtask

  task automatic test_div_zero();
    logic [63:0] res; int cyc;
    run_div(1'b0, 32'h1234, 32'h0, 1'b0, res, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL divzero_latency got %0d want 2", cyc); end
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL divzero_result got %h want 0", res); end
    step();
  endtask

  task automatic test_annul();
    logic [63:0] res, prev; int cyc; int seen;
    prev = result;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    annul = 1'b1;
    step();
    annul = 1'b0;
    checks++; if (dbgState !== 2'd0 || ready !== 1'b0) begin errors++; $display("FAIL annul_free got state=%0d ready=%b want 0/0", dbgState, ready); end
    checks++; if (result !== prev) begin errors++; $display("FAIL annul_result got %h want %h", result, prev); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin step(); if (ready) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL annul_no_ready got %0d ready cycles want 0", seen); end
    run_div(1'b0, 32'd9, 32'd3, 1'b0, res, cyc);
    checks++; if (res !== 64'h00000000_00000003) begin errors++; $display("FAIL annul_then_9_3 got %h want 0000000000000003", res); end
    step();
  endtask

  task automatic test_hold();
    logic [63:0] res; int cyc; int bad;
    run_div(1'b0, 32'd20, 32'd6, 1'b0, res, cyc);
    hold = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ready !== 1'b1 || result !== 64'h00000002_00000003) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0 (last %h)", bad, result); end
    hold = 1'b0;
    step();
    checks++; if (dbgState !== 2'd0 || ready !== 1'b0) begin errors++; $display("FAIL hold_release got state=%0d ready=%b want 0/0", dbgState, ready); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (ready !== 1'b0 || result !== 64'h0) begin errors++; $display("FAIL reset_mid got ready=%b result=%h want 0/0", ready, result); end
    checks++; if (dbgState !== 2'd0) begin errors++; $display("FAIL reset_mid_state got %0d want 0", dbgState); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; int cyc;
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, 1'b1, res, cyc);
    checks++; if (res !== 64'h0000000F_0FFFFFFF) begin errors++; $display("FAIL b2b_first got %h want 0000000f0fffffff", res); end
    opdata1 = 32'd20; opdata2 = 32'd6;
    step();
    checks++; if (dbgState !== 2'd0 || ready !== 1'b0) begin errors++; $display("FAIL b2b_free got state=%0d ready=%b want 0/0", dbgState, ready); end
    cyc = 0;
    wait_ready(100, cyc);
    start = 1'b0;
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", cyc); end
    checks++; if (result !== 64'h00000002_00000003) begin errors++; $display("FAIL b2b_second got %h want 0000000200000003", result); end
    step();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
